// File: rtl/fu_pipe_bypass.sv
// Fixed-latency functional-unit pipeline: carries issued instructions through NUM_STAGES
// rigid stages, forms ext(imm) on entry to the output stage, and answers per-port bypass lookups.
module fu_pipe_bypass #(
    parameter int NUM_STAGES = 6,
    parameter int DATA_W     = 16,
    parameter int IMM_W      = 9,
    parameter int ADDR_W     = 3,
    parameter int TICKET_W   = 3,
    parameter int PC_W       = 16,
    parameter int NUM_OPS    = 2,
    parameter int SIGN_EXT   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_dest_addr,
    input  logic                         in_we,
    input  logic [TICKET_W-1:0]          in_ticket,
    input  logic [PC_W-1:0]              in_pc,
    input  logic [IMM_W-1:0]             in_imm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_dest_addr,
    output logic                         out_we,
    output logic [TICKET_W-1:0]          out_ticket,
    output logic [PC_W-1:0]              out_pc,
    output logic [DATA_W-1:0]            out_result,
    input  logic [NUM_OPS*ADDR_W-1:0]    op_addr,
    input  logic [NUM_OPS*TICKET_W-1:0]  op_ticket,
    output logic [2*NUM_OPS-1:0]         bypass_status,
    output logic [NUM_OPS*DATA_W-1:0]    bypass_data
);

    localparam int LAST = NUM_STAGES - 1;

    logic                r_valid  [NUM_STAGES];
    logic [ADDR_W-1:0]   r_dest   [NUM_STAGES];
    logic                r_we     [NUM_STAGES];
    logic [TICKET_W-1:0] r_ticket [NUM_STAGES];
    logic [PC_W-1:0]     r_pc     [NUM_STAGES];
    logic [IMM_W-1:0]    r_imm    [NUM_STAGES-1];
    logic [DATA_W-1:0]   r_result;

    logic                w_advance;
    logic [DATA_W-1:0]   w_ext;

    // A stalled output freezes the whole pipe; bubbles never collapse.
    assign w_advance = ~r_valid[LAST] | out_ready;
    assign in_ready  = w_advance & ~flush;

    always_comb begin
        w_ext            = {DATA_W{(SIGN_EXT != 0) && r_imm[LAST-1][IMM_W-1]}};
        w_ext[IMM_W-1:0] = r_imm[LAST-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the shift into one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STAGES; s++) r_valid[s] <= 1'b0;
        end else if (flush) begin
            for (int s = 0; s < NUM_STAGES; s++) r_valid[s] <= 1'b0;
        end else if (w_advance) begin
            r_valid[0] <= in_valid & in_ready;
            for (int s = 1; s < NUM_STAGES; s++) r_valid[s] <= r_valid[s-1];
        end
    end

    // NOTE: payloads are reset as well, because outputs and bypass data must read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_dest[s]   <= '0;
                r_we[s]     <= 1'b0;
                r_ticket[s] <= '0;
                r_pc[s]     <= '0;
            end
            for (int s = 0; s < NUM_STAGES - 1; s++) r_imm[s] <= '0;
            r_result <= '0;
        end else if (w_advance) begin
            r_dest[0]   <= in_dest_addr;
            r_we[0]     <= in_we;
            r_ticket[0] <= in_ticket;
            r_pc[0]     <= in_pc;
            r_imm[0]    <= in_imm;
            for (int s = 1; s < NUM_STAGES; s++) begin
                r_dest[s]   <= r_dest[s-1];
                r_we[s]     <= r_we[s-1];
                r_ticket[s] <= r_ticket[s-1];
                r_pc[s]     <= r_pc[s-1];
            end
            for (int s = 1; s < NUM_STAGES - 1; s++) r_imm[s] <= r_imm[s-1];
            r_result <= w_ext;
        end
    end

    // Walk oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        bypass_status = '0;
        bypass_data   = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            for (int s = LAST; s >= 0; s--) begin
                if (r_valid[s] && r_we[s] &&
                    r_dest[s] == op_addr[k*ADDR_W +: ADDR_W] &&
                    r_ticket[s] == op_ticket[k*TICKET_W +: TICKET_W]) begin
                    bypass_status[2*k +: 2]         = (s == LAST) ? 2'b11 : 2'b10;
                    bypass_data[k*DATA_W +: DATA_W] = (s == LAST) ? r_result : '0;
                end
            end
        end
    end

    assign out_valid     = r_valid[LAST];
    assign out_dest_addr = r_dest[LAST];
    assign out_we        = r_we[LAST];
    assign out_ticket    = r_ticket[LAST];
    assign out_pc        = r_pc[LAST];
    assign out_result    = r_result;

endmodule

// File: tb/tb_fu_pipe_bypass.sv
// Directed bench for fu_pipe_bypass: scoreboard of issued beats checked at the output handshake,
// plus latency, stall, bypass-priority, flush and async-reset checks.
module tb_fu_pipe_bypass;

    typedef struct packed {
        logic [2:0]  dest;
        logic        we;
        logic [2:0]  ticket;
        logic [15:0] pc;
        logic [15:0] res;
        logic [15:0] res_sx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_we, out_valid, out_ready, out_we;
    logic [2:0]  in_dest_addr, in_ticket, out_dest_addr, out_ticket;
    logic [15:0] in_pc, out_pc, out_result;
    logic [8:0]  in_imm;
    logic [5:0]  op_addr, op_ticket;
    logic [3:0]  bypass_status;
    logic [31:0] bypass_data;

    logic        sx_in_ready, sx_out_valid, sx_out_we;
    logic [2:0]  sx_out_dest_addr, sx_out_ticket;
    logic [15:0] sx_out_pc, out_result_sx;
    logic [3:0]  sx_bypass_status;
    logic [31:0] sx_bypass_data;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_out    = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fu_pipe_bypass #(.SIGN_EXT(0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest_addr(in_dest_addr), .in_we(in_we), .in_ticket(in_ticket), .in_pc(in_pc),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_dest_addr(out_dest_addr), .out_we(out_we), .out_ticket(out_ticket),
        .out_pc(out_pc), .out_result(out_result), .op_addr(op_addr), .op_ticket(op_ticket),
        .bypass_status(bypass_status), .bypass_data(bypass_data)
    );

    fu_pipe_bypass #(.SIGN_EXT(1)) u_dut_sx (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(sx_in_ready),
        .in_dest_addr(in_dest_addr), .in_we(in_we), .in_ticket(in_ticket), .in_pc(in_pc),
        .in_imm(in_imm), .out_valid(sx_out_valid), .out_ready(out_ready),
        .out_dest_addr(sx_out_dest_addr), .out_we(sx_out_we), .out_ticket(sx_out_ticket),
        .out_pc(sx_out_pc), .out_result(out_result_sx), .op_addr(op_addr), .op_ticket(op_ticket),
        .bypass_status(sx_bypass_status), .bypass_data(sx_bypass_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] d, input logic w, input logic [2:0] t,
                                input logic [15:0] p, input logic [8:0] i);
        exp_t e;
        e.dest   = d;
        e.we     = w;
        e.ticket = t;
        e.pc     = p;
        e.res    = {7'b0, i};
        e.res_sx = {{7{i[8]}}, i};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] d, input logic w, input logic [2:0] t,
                         input logic [15:0] p, input logic [8:0] i);
        in_valid = 1'b1; in_dest_addr = d; in_we = w; in_ticket = t; in_pc = p; in_imm = i;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: sample half a cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("out_without_issue", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_payload",
                          64'({out_dest_addr, out_we, out_ticket, out_pc, out_result, out_result_sx}),
                          64'(mon_e));
                    n_out++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back(mk(in_dest_addr, in_we, in_ticket, in_pc, in_imm));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_dest_addr = '0; in_we = 1'b0; in_ticket = '0; in_pc = '0; in_imm = '0;
        op_addr = '0; op_ticket = '0;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_bus", 64'({out_dest_addr, out_we, out_ticket, out_pc, out_result}), 64'd0);
        check("rst_bypass", 64'({bypass_status, bypass_data}), 64'd0);
        #10 reset = 1'b1;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single issue: latency and zero/sign extension
        issue(3'd3, 1'b1, 3'd5, 16'h0040, 9'h1FF);
        step();
        idle();
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("lat_valid_c%0d", c), 64'(out_valid), 64'(c == 5));
        end
        check("lat_result_zext", 64'(out_result), 64'h01FF);
        check("lat_result_sext", 64'(out_result_sx), 64'hFFFF);
        check("lat_fields", 64'({out_dest_addr, out_we, out_ticket, out_pc}), 64'({3'd3, 1'b1, 3'd5, 16'h0040}));
        drain("t1_drain");

        // Back-to-back with a 3-cycle output stall
        n0 = n_out;
        for (int i = 0; i < 6; i++) begin
            issue(3'(i), 1'b1, 3'(i), 16'h0100 + 16'(i), 9'(i * 37));
            step();
        end
        check("t2_first_at_out", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        issue(3'd6, 1'b1, 3'd6, 16'h0106, 9'(6 * 37));
        op_addr = {3'd0, 3'd5};
        op_ticket = {3'd0, 3'd5};
        for (int j = 0; j < 3; j++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_pc", 64'({out_valid, out_pc}), 64'({1'b1, 16'h0100}));
            check("stall_stage0_byp", 64'(bypass_status[1:0]), 64'h2);
            step();
        end
        out_ready = 1'b1;
        step();
        issue(3'd7, 1'b1, 3'd7, 16'h0107, 9'(7 * 37));
        step();
        idle();
        drain("t2_drain");
        check("t2_count", 64'(n_out - n0), 64'd8);

        // Bypass: stage 1 in flight, output stage with data, we=0 ignored
        out_ready = 1'b0;
        issue(3'd2, 1'b1, 3'd4, 16'h0200, 9'h055); step();
        idle(); step();
        issue(3'd5, 1'b0, 3'd6, 16'h0202, 9'h011); step();
        idle(); step();
        issue(3'd2, 1'b1, 3'd1, 16'h0204, 9'h0AA); step();
        idle(); step();
        op_addr = {3'd2, 3'd2};
        op_ticket = {3'd4, 3'd1};
        #1;
        check("byp_p0_status", 64'(bypass_status[1:0]), 64'h2);
        check("byp_p0_data", 64'(bypass_data[15:0]), 64'h0);
        check("byp_p1_status", 64'(bypass_status[3:2]), 64'h3);
        check("byp_p1_data", 64'(bypass_data[31:16]), 64'h0055);
        op_addr = {3'd2, 3'd5};
        op_ticket = {3'd4, 3'd6};
        #1;
        check("byp_we0_status", 64'(bypass_status[1:0]), 64'h0);
        check("byp_we0_data", 64'(bypass_data[15:0]), 64'h0);
        out_ready = 1'b1;
        drain("t3_drain");

        // Youngest wins: same dest/ticket in stage 0 and output stage
        issue(3'd7, 1'b1, 3'd3, 16'h0300, 9'h123); step();
        idle();
        for (int j = 0; j < 4; j++) step();
        issue(3'd7, 1'b1, 3'd3, 16'h0305, 9'h0F0); step();
        idle();
        op_addr = {3'd7, 3'd7};
        op_ticket = {3'd2, 3'd3};
        #1;
        check("young_out_valid", 64'(out_valid), 64'd1);
        check("young_status", 64'(bypass_status), 64'h2);
        check("young_data", 64'(bypass_data), 64'h0);
        drain("t4_drain");

        // Flush together with an issue on a full pipe
        for (int i = 0; i < 6; i++) begin
            issue(3'(i), 1'b1, 3'(i), 16'h0400 + 16'(i), 9'(i + 3));
            step();
        end
        flush = 1'b1;
        issue(3'd6, 1'b1, 3'd6, 16'h0406, 9'h009);
        op_addr = {3'd0, 3'd5};
        op_ticket = {3'd0, 3'd5};
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        idle();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_bypass", 64'(bypass_status), 64'h0);
        for (int j = 0; j < 8; j++) begin
            step();
            check("flush_no_output", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) begin
            issue(3'(i), 1'b1, 3'(7 - i), 16'h0500 + 16'(i), 9'(i * 11));
            step();
        end
        op_addr = {3'd0, 3'd6};
        op_ticket = {3'd7, 3'd1};
        #3 reset = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_bus", 64'({out_dest_addr, out_we, out_ticket, out_pc, out_result}), 64'd0);
        check("arst_bypass", 64'({bypass_status, bypass_data}), 64'd0);
        idle();
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        issue(3'd6, 1'b1, 3'd2, 16'h0600, 9'h100);
        step();
        idle();
        for (int c = 1; c <= 5; c++) begin
            step();
            check($sformatf("arst_lat_c%0d", c), 64'(out_valid), 64'(c == 5));
        end
        check("arst_result", 64'({out_result, out_result_sx}), 64'({16'h0100, 16'hFF00}));
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fu_pipe_bypass.md
# fu_pipe_bypass

Parametrised fixed-latency functional-unit pipeline with backpressure, flush and multi-port bypass lookup. It carries each issued instruction's destination register, write enable, ROB ticket, PC and immediate through `NUM_STAGES` registered stages, and forms the result when the instruction enters the output stage. Every cycle it reports to decode, for each source operand port, whether the operand's producer is in flight (not ready) or sitting in the output stage with data available. It sits between decode/issue and the ROB write port.

## Interface
Parameters:
- `NUM_STAGES`, 6, pipeline depth, ≥2; the last stage is the output stage
- `DATA_W`, 16, result width
- `IMM_W`, 9, immediate width, ≤ `DATA_W`
- `ADDR_W`, 3, register address width
- `TICKET_W`, 3, ROB ticket width
- `PC_W`, 16, PC width
- `NUM_OPS`, 2, number of bypass lookup ports
- `SIGN_EXT`, 0, 1 = sign-extend the immediate, 0 = zero-extend it

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low
- `flush` in 1: synchronous kill of all in-flight instructions
- `in_valid` in 1: issue request
- `in_ready` out 1: issue accepted when `in_valid & in_ready`
- `in_dest_addr` in `ADDR_W`; `in_we` in 1; `in_ticket` in `TICKET_W`; `in_pc` in `PC_W`; `in_imm` in `IMM_W`
- `out_valid` out 1: output stage holds a live instruction
- `out_ready` in 1: ROB accepts the output
- `out_dest_addr`, `out_we`, `out_ticket`, `out_pc`, `out_result` out: output stage contents (`out_result` is `DATA_W` wide)
- `op_addr` in `NUM_OPS*ADDR_W`: port k at bits [k*ADDR_W +: ADDR_W]
- `op_ticket` in `NUM_OPS*TICKET_W`: same packing
- `bypass_status` out `2*NUM_OPS`: per port, 00 = no match, 10 = in flight, 11 = in output stage with data
- `bypass_data` out `NUM_OPS*DATA_W`: per-port data

## Operation
- Each stage s holds a valid bit plus a payload. Stages 0…N-2 carry the immediate. The output stage carries `result = ext(imm)` (zero- or sign-extended per `SIGN_EXT`), computed on entry.
- `advance = ~out_valid | out_ready`. When `advance` is high, every stage shifts by one. Stage 0 loads the input payload with `valid = in_valid & in_ready`. When `advance` is low, all stages hold.
- `in_ready = advance & ~flush`. The pipeline is a rigid shift; internal bubbles do not collapse.
- `flush`: on the next edge, every valid bit (output stage included) clears and any same-cycle input is dropped. Payload registers are not cleared. `flush` overrides `advance`.
- Reset: all valid bits and payloads are 0. As a result, every `out_*` is 0, `bypass_status` is 0 and `bypass_data` is 0.
- Bypass lookup is purely combinational from the current stage contents and `op_addr`/`op_ticket`.
  - Stage s matches port k when `valid_s & we_s & dest_s==op_addr[k] & ticket_s==op_ticket[k]`.
  - Priority is youngest first: stage 0 highest, output stage lowest.
  - If the first matching stage is below N-1, status is 10 and data is 0.
  - If the first matching stage is the output stage, status is 11 and data is `out_result`.
  - If nothing matches, status is 00 and data is 0.
- Lookup ignores `flush` and `advance` in the same cycle; it reflects the registered state only.

## Timing
- Latency: an instruction accepted at edge t shows `out_valid` after edge t+N-1. It is visible in stage 0 after edge t. With no stalls it is on the output N cycles after the issue cycle (6 for the defaults).
- Throughput is one per cycle while `out_ready` stays high.
- An output stall holds the whole pipe. `in_ready` drops in the same cycle that `out_valid & ~out_ready`.
- Output handshake completes on an edge with `out_valid & out_ready`.
- `in_ready` may depend combinationally on `out_ready`.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first issue is accepted on the first edge after release.
- Flush and issue in the same cycle: the issue is dropped and `in_ready` reads 0.

## Test plan
- Reset, then issue dest=3, we=1, ticket=5, pc=16'h0040, imm=9'h1FF with `out_ready`=1. Require `out_valid` exactly 6 cycles later with `out_result`=16'h01FF (`SIGN_EXT`=0). With `SIGN_EXT`=1, require 16'hFFFF.
- Issue 8 back-to-back instructions, hold `out_ready`=0 for 3 cycles once the first reaches the output. Require `in_ready`=0 and all stages frozen during the stall, then all 8 results delivered in order with no loss or duplication.
- Place dest=2/ticket=1 in stage 1 and dest=2/ticket=4 in the output stage. Port0 {2,1} must return 10 with data 0; port1 {2,4} must return 11 with data equal to `out_result`. A matching entry with we=0 must return 00.
- Place the same dest and ticket in both stage 0 and the output stage. Require status 10 (youngest wins).
- Fill the pipe, then assert `flush` together with `in_valid`. Require that the next cycle has `out_valid`=0, all `bypass_status`=00, and no output from the dropped beat.
- Assert `reset` low asynchronously mid-stream. Require all outputs to be 0 before the next clock edge; after release, a fresh issue appears after 6 cycles.
